// File: rtl/invalidate_collector.sv
// invalidate_collector: sequences one L2 coherence invalidation across NUM_CACHE L1 caches.
//   l2_inv_valid/ready/addr     : request from L2, accepted only in IDLE
//   invalidate_req/addr         : broadcast to all L1s while collecting acks
//   invalidate_resp/dirty/wdata : per-cache ack pulse, dirty flag and line data
//   done_*                      : completion record, held until done_ready
module invalidate_collector #(
    parameter int NUM_CACHE = 2,
    parameter int XLEN      = 32,
    parameter int LINE_W    = 256,
    parameter int TIMEOUT   = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        l2_inv_valid,
    output logic                        l2_inv_ready,
    input  logic [XLEN-1:0]             l2_inv_addr,
    output logic                        invalidate_req,
    output logic [XLEN-1:0]             invalidate_addr,
    input  logic [NUM_CACHE-1:0]        invalidate_resp,
    input  logic [NUM_CACHE-1:0]        invalidate_dirty,
    input  logic [NUM_CACHE*LINE_W-1:0] invalidate_wdata,
    output logic                        done_valid,
    input  logic                        done_ready,
    output logic                        done_dirty,
    output logic [LINE_W-1:0]           done_wdata,
    output logic                        done_timeout,
    output logic                        done_multi_dirty
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                state_q, state_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [NUM_CACHE-1:0]  pend_q, pend_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  dirty_q, dirty_d, multi_q, multi_d, tout_q, tout_d;
    logic [LINE_W-1:0]     wdata_q, wdata_d, wsel;
    logic [NUM_CACHE-1:0]  acc, dacc;

    always_comb begin
        acc  = invalidate_resp & pend_q;
        dacc = acc & invalidate_dirty;
        // descending scan so the lowest dirty index wins
        wsel = '0;
        for (int i = NUM_CACHE - 1; i >= 0; i--)
            if (dacc[i]) wsel = invalidate_wdata[i*LINE_W +: LINE_W];
        state_d = state_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        timer_d = timer_q;
        dirty_d = dirty_q;
        multi_d = multi_q;
        tout_d  = tout_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (l2_inv_valid) begin
                state_d = COLLECT;
                addr_d  = l2_inv_addr;
                pend_d  = '1;
                timer_d = '0;
                dirty_d = 1'b0;
                multi_d = 1'b0;
                tout_d  = 1'b0;
                wdata_d = '0;
            end
            COLLECT: begin
                pend_d  = pend_q & ~acc;
                timer_d = timer_q + TW'(1);
                if (dacc != '0) begin
                    dirty_d = 1'b1;
                    wdata_d = dirty_q ? wdata_q : wsel;
                    // a prior capture, or two dirty bits at once, is a protocol error
                    multi_d = multi_q | dirty_q | ((dacc & (dacc - NUM_CACHE'(1))) != '0);
                end
                if (pend_d == '0)
                    state_d = DONE;
                else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    tout_d  = 1'b1;
                end
            end
            DONE: if (done_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pend_q  <= '0;
            timer_q <= '0;
            dirty_q <= 1'b0;
            multi_q <= 1'b0;
            tout_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            timer_q <= timer_d;
            dirty_q <= dirty_d;
            multi_q <= multi_d;
            tout_q  <= tout_d;
            wdata_q <= wdata_d;
        end
    end

    assign l2_inv_ready     = state_q == IDLE;
    assign invalidate_req   = state_q == COLLECT;
    assign invalidate_addr  = addr_q;
    assign done_valid       = state_q == DONE;
    assign done_dirty       = done_valid & dirty_q;
    assign done_wdata       = done_valid ? wdata_q : '0;
    assign done_timeout     = done_valid & tout_q;
    assign done_multi_dirty = done_valid & multi_q;
endmodule

// File: tb/tb_invalidate_collector.sv
// tb_invalidate_collector: random and directed invalidations checked against a schedule-level model.
module tb_invalidate_collector;
    localparam int N  = 2;
    localparam int LW = 256;
    localparam int XL = 32;
    localparam int TO = 8;
    localparam int SC = TO + 2;

    logic              clk = 0, rst = 0;
    logic              l2_inv_valid = 0, l2_inv_ready;
    logic [XL-1:0]     l2_inv_addr = '0;
    logic              invalidate_req;
    logic [XL-1:0]     invalidate_addr;
    logic [N-1:0]      invalidate_resp = '0, invalidate_dirty = '0;
    logic [N*LW-1:0]   invalidate_wdata = '0;
    logic              done_valid, done_ready = 0, done_dirty, done_timeout, done_multi_dirty;
    logic [LW-1:0]     done_wdata;

    int n_cmp = 0, n_bad = 0;
    bit            pulse [N][SC];
    bit            dty   [N][SC];
    logic [LW-1:0] wd    [N][SC];

    invalidate_collector #(.NUM_CACHE(N), .XLEN(XL), .LINE_W(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .l2_inv_valid(l2_inv_valid), .l2_inv_ready(l2_inv_ready), .l2_inv_addr(l2_inv_addr),
        .invalidate_req(invalidate_req), .invalidate_addr(invalidate_addr),
        .invalidate_resp(invalidate_resp), .invalidate_dirty(invalidate_dirty),
        .invalidate_wdata(invalidate_wdata),
        .done_valid(done_valid), .done_ready(done_ready), .done_dirty(done_dirty),
        .done_wdata(done_wdata), .done_timeout(done_timeout), .done_multi_dirty(done_multi_dirty)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [LW-1:0] got, logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int j = 0; j < LW / 32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic clear_sched();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < SC; k++) begin
                pulse[i][k] = 0;
                dty[i][k]   = 0;
                wd[i][k]    = rnd_line();
            end
    endtask

    task automatic random_sched();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < SC; k++) begin
                pulse[i][k] = $urandom_range(0, 5) == 0;
                dty[i][k]   = $urandom_range(0, 2) == 0;
                wd[i][k]    = rnd_line();
            end
    endtask

    task automatic run_txn(input logic [XL-1:0] a, input int hold);
        int fst [N];
        int maxf, cyc, nd, bestk, k, req_cnt;
        bit tout;
        logic [LW-1:0] ew, snap;
        // model: each cache's first pulse is its ack; completion when all acked, else timeout
        maxf = 0;
        for (int i = 0; i < N; i++) begin
            fst[i] = 99;
            for (int kk = SC - 1; kk >= 0; kk--) if (pulse[i][kk]) fst[i] = kk;
            if (fst[i] > maxf) maxf = fst[i];
        end
        tout = maxf > TO - 1;
        cyc  = tout ? TO : maxf + 1;
        nd = 0; bestk = 99; ew = '0;
        for (int i = 0; i < N; i++)
            if (fst[i] < cyc && dty[i][fst[i]]) begin
                nd++;
                if (fst[i] < bestk) begin
                    bestk = fst[i];
                    ew = wd[i][fst[i]];
                end
            end
        @(negedge clk);
        check("ready_idle", {255'b0, l2_inv_ready}, 1);
        l2_inv_valid = 1;
        l2_inv_addr  = a;
        @(posedge clk);
        #1;
        l2_inv_valid = 0;
        l2_inv_addr  = $urandom;
        k = 0; req_cnt = 0;
        forever begin
            @(negedge clk);
            if (done_valid) break;
            if (k >= 40) begin
                check("collect_budget", k, cyc);
                break;
            end
            if (invalidate_req) req_cnt++;
            if (k == 0) check("bcast_addr", invalidate_addr, a);
            for (int i = 0; i < N; i++) begin
                invalidate_resp[i]  = k < SC ? pulse[i][k] : 1'b0;
                invalidate_dirty[i] = k < SC ? dty[i][k] : 1'b0;
                invalidate_wdata[i*LW +: LW] = k < SC ? wd[i][k] : rnd_line();
            end
            k++;
        end
        invalidate_resp = '0;
        invalidate_dirty = '0;
        check("req_cycles", req_cnt, cyc);
        check("done_dirty", {255'b0, done_dirty}, {255'b0, nd > 0});
        check("done_wdata", done_wdata, ew);
        check("done_timeout", {255'b0, done_timeout}, {255'b0, tout});
        check("done_multi", {255'b0, done_multi_dirty}, {255'b0, nd > 1});
        check("done_req_low", {255'b0, invalidate_req}, 0);
        check("done_ready_low", {255'b0, l2_inv_ready}, 0);
        snap = done_wdata;
        for (int h = 0; h < hold; h++) begin
            invalidate_resp  = N'($urandom);
            invalidate_dirty = '1;
            for (int i = 0; i < N; i++) invalidate_wdata[i*LW +: LW] = rnd_line();
            @(negedge clk);
            check("hold_valid", {255'b0, done_valid}, 1);
            check("hold_wdata", done_wdata, snap);
            check("hold_dirty", {255'b0, done_dirty}, {255'b0, nd > 0});
            check("hold_multi", {255'b0, done_multi_dirty}, {255'b0, nd > 1});
            check("hold_ready", {255'b0, l2_inv_ready}, 0);
        end
        invalidate_resp  = '0;
        invalidate_dirty = '0;
        done_ready = 1;
        @(negedge clk);
        done_ready = 0;
        check("post_valid", {255'b0, done_valid}, 0);
        check("post_ready", {255'b0, l2_inv_ready}, 1);
        check("post_addr", invalidate_addr, a);
    endtask

    initial begin
        #1;
        check("rst_req", {255'b0, invalidate_req}, 0);
        check("rst_valid", {255'b0, done_valid}, 0);
        check("rst_wdata", done_wdata, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rel_ready", {255'b0, l2_inv_ready}, 1);

        clear_sched();
        pulse[0][1] = 1; pulse[1][3] = 1;
        run_txn(32'h8000_0040, 0);

        clear_sched();
        pulse[1][0] = 1; dty[1][0] = 1; wd[1][0] = {32{8'hA5}};
        pulse[0][2] = 1;
        run_txn($urandom, 0);

        clear_sched();
        pulse[0][0] = 1; dty[0][0] = 1; wd[0][0] = {32{8'h11}};
        pulse[1][0] = 1; dty[1][0] = 1; wd[1][0] = {32{8'h22}};
        run_txn($urandom, 0);

        clear_sched();
        pulse[0][0] = 1;
        run_txn($urandom, 0);

        clear_sched();
        pulse[0][0] = 1; pulse[1][7] = 1;
        run_txn($urandom, 0);

        clear_sched();
        pulse[0][0] = 1; dty[0][0] = 1; pulse[1][2] = 1;
        run_txn($urandom, 5);

        for (int t = 0; t < 40; t++) begin
            random_sched();
            run_txn($urandom, $urandom_range(0, 3));
        end

        @(negedge clk);
        l2_inv_valid = 1;
        l2_inv_addr  = $urandom;
        @(negedge clk);
        l2_inv_valid = 0;
        @(negedge clk);
        check("mid_req", {255'b0, invalidate_req}, 1);
        rst = 0;
        #1;
        check("abort_req", {255'b0, invalidate_req}, 0);
        check("abort_valid", {255'b0, done_valid}, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("abort_ready", {255'b0, l2_inv_ready}, 1);
        check("abort_novalid", {255'b0, done_valid}, 0);

        random_sched();
        run_txn($urandom, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/invalidate_collector.md
Name: invalidate_collector

Overview:
- Sequences one coherence invalidation at a time for the L2 cache.
- Broadcasts the invalidate request and address to all NUM_CACHE L1 caches, then collects each cache's acknowledge.
- Captures the dirty line from whichever cache returns one, bounds the wait with a timeout, and hands a single completion record back to the L2.
- Sits between the l2cache invalidation port and the per-core icache/dcache invalidation ports, replacing the combinational response mux.

Parameters:
NUM_CACHE, 2, number of L1 caches on the invalidate network (1..16)
XLEN, 32, address width
LINE_W, 256, cacheline width in bits
TIMEOUT, 64, max cycles spent in COLLECT before forced completion (>=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
l2_inv_valid  input  1  L2 requests an invalidation
l2_inv_ready  output  1  collector can accept a request
l2_inv_addr  input  XLEN  line address to invalidate
invalidate_req  output  1  broadcast request to all L1s
invalidate_addr  output  XLEN  broadcast address (latched)
invalidate_resp  input  NUM_CACHE  per-cache acknowledge, one-cycle pulse
invalidate_dirty  input  NUM_CACHE  qualifies resp: cache held line dirty
invalidate_wdata  input  NUM_CACHE*LINE_W  per-cache line data, slice i = bits [i*LINE_W +: LINE_W]
done_valid  output  1  completion record valid
done_ready  input  1  L2 accepts completion
done_dirty  output  1  a dirty line was captured
done_wdata  output  LINE_W  captured dirty line (0 if none)
done_timeout  output  1  completion forced by timeout
done_multi_dirty  output  1  more than one cache reported dirty (protocol error)

Behaviour:
- Reset (rst=0, async): state IDLE.
  - Outputs: l2_inv_ready=1 after reset release; all other outputs 0; pending mask 0; timer 0.
  - Reset mid-operation aborts without a completion record.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - l2_inv_ready=1.
  - On l2_inv_valid=1, latch l2_inv_addr into invalidate_addr, set pending mask to all ones, clear timer and capture registers, and go to COLLECT.
  - Accept-to-broadcast latency is 1 cycle.
- COLLECT:
  - invalidate_req=1, l2_inv_ready=0.
  - Each cycle, clear pending[i] for every i with invalidate_resp[i]=1 and pending[i]=1.
  - Ignore responses from caches already cleared.
  - Dirty capture: for each accepted resp with dirty=1:
    - If nothing is captured yet, store the lowest such index's wdata and set done_dirty.
    - A second dirty response (same cycle or later) sets done_multi_dirty; the first capture is retained.
  - Responses in the first COLLECT cycle are valid.
  - Exit when (pending & ~accepted_resp)==0, giving DONE on the next cycle. The last ack and the transition share an edge.
  - Timer increments each COLLECT cycle. If the timer equals TIMEOUT-1 and pending is not cleared this cycle, go to DONE with done_timeout=1.
  - Completion and timeout in the same cycle: completion wins, done_timeout=0.
- DONE:
  - invalidate_req=0, done_valid=1.
  - done_* are held stable until done_ready=1, then go to IDLE.
  - l2_inv_ready stays 0 in DONE, so a new request cannot overlap. The earliest new accept is the cycle after the handshake.
- invalidate_resp outside COLLECT is ignored and has no side effects.
- invalidate_addr holds its value after DONE until the next accept.
- done_wdata is 0 when done_dirty=0.

Test Plan:
- All clean: NUM_CACHE=2, accept addr 0x8000_0040.
  - resp[0] pulses on COLLECT cycle 1, resp[1] on cycle 3, dirty=0.
  - Required: invalidate_req high for exactly 4 cycles; done_valid with dirty=0, timeout=0, wdata=0.
- Single dirty: resp[1] with dirty=1 and wdata=256'hA5...A5 on cycle 0, then resp[0] clean on cycle 2.
  - Required: done_dirty=1, done_wdata=A5..A5, done_multi_dirty=0.
- Simultaneous dirty: both resp with dirty=1 in the same cycle, wdata0=0x11.., wdata1=0x22...
  - Required: done_wdata=0x11.., done_multi_dirty=1.
- Timeout: TIMEOUT=8, only cache 0 responds.
  - Required: DONE entered after 8 COLLECT cycles with done_timeout=1.
  - Variant: cache 1 responds on cycle 7. Required: done_timeout=0.
- Backpressure and reset:
  - Hold done_ready=0 for 5 cycles. Required: done_* stable, l2_inv_ready=0, extra resp pulses ignored.
  - Then assert rst=0 mid-COLLECT on a second request. Required: immediately invalidate_req=0, done_valid=0; l2_inv_ready=1 after release.
